// File: rtl/chu_vga_multi_square_core.sv
// Multi-square sprite overlay: NS programmable filled squares drawn over the
// incoming video stream, with per-square bounce motion, overlap detection and
// a frame counter, all reachable through the slot register interface.
module chu_vga_multi_square_core #(
    parameter int             CD        = 12,
    parameter int             NS        = 4,
    parameter int             SW        = 6,
    parameter logic [CD-1:0]  KEY_COLOR = '0,
    parameter int             H_ACTIVE  = 640,
    parameter int             V_ACTIVE  = 480
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          cs,
    input  logic          write,
    input  logic          read,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);

    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CD-1:0] RESET_COLOR = CD'(12'hF00);

    typedef enum logic {IDLE, UPDATE} state_t;

    logic [10:0]   x0_r   [NS];
    logic [10:0]   y0_r   [NS];
    logic [SW-1:0] size_r [NS];
    logic [CD-1:0] col_r  [NS];
    logic [3:0]    vx_r   [NS];
    logic [3:0]    vy_r   [NS];
    logic [NS-1:0] en_r;
    logic [NS-1:0] mot_r;
    logic          bypass_r;
    logic [NS-1:0] status_r;
    logic [NS-1:0] live_r;
    logic [15:0]   frame_cnt;
    logic          tick_cond_q;
    state_t        state;
    logic [IW-1:0] idx;

    logic [NS-1:0] hit;
    logic [CD-1:0] pix_col;
    logic          spr_wr;
    logic          glb_wr;
    logic          tick_cond;
    logic          tick;
    logic          coll;
    logic          unused_bits;

    assign spr_wr      = cs & write & addr[13] & ~addr[12];
    assign glb_wr      = cs & write & addr[13] & addr[12];
    assign tick_cond   = (x == 11'd0) && (y == 11'(V_ACTIVE));
    assign tick        = tick_cond & ~tick_cond_q;
    assign coll        = (x < 11'(H_ACTIVE)) && (y < 11'(V_ACTIVE)) && (|(hit & (hit - 1'b1)));
    assign unused_bits = ^{read, addr[11:8], wr_data[31:11]};

    // One axis of the bounce step: returns {new position, new velocity}.
    // Arithmetic is widened so large positions cannot wrap into negatives.
    function automatic logic [14:0] bounce(input logic [10:0] pos, input logic [3:0] vel,
                                           input logic [SW-1:0] size, input int limit);
        logic signed [13:0] np;
        logic signed [13:0] sd;
        logic signed [13:0] lim;
        logic [3:0]         nv;
        np  = 14'({3'b000, pos}) + {{10{vel[3]}}, vel};
        sd  = 14'(size) + 14'sd1;
        lim = 14'(limit);
        nv  = (vel == 4'b1000) ? 4'd7 : 4'(~vel + 4'd1);
        if (np < 0) begin
            return {11'd0, nv};
        end else if (np + sd > lim) begin
            return {11'(lim - sd), nv};
        end else begin
            return {np[10:0], vel};
        end
    endfunction

    // Per-square hit test against the current pixel, done in 12 bits so the right edge never wraps.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NS; i++) begin
            hit[i] = en_r[i] && (col_r[i] != KEY_COLOR)
                  && ({1'b0, x} >= {1'b0, x0_r[i]})
                  && ({1'b0, x} <  ({1'b0, x0_r[i]} + 12'(size_r[i]) + 12'd1))
                  && ({1'b0, y} >= {1'b0, y0_r[i]})
                  && ({1'b0, y} <  ({1'b0, y0_r[i]} + 12'(size_r[i]) + 12'd1));
        end
    end

    // Lowest-numbered hitting square wins; with no hit the incoming pixel passes through.
    always_comb begin
        pix_col = si_rgb;
        for (int i = NS - 1; i >= 0; i--) begin
            if (hit[i]) pix_col = col_r[i];
        end
    end

    // Output pixel register giving the fixed one-clock latency in every mode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) so_rgb <= '0;
        else          so_rgb <= bypass_r ? si_rgb : pix_col;
    end

    // Motion sequencer: a frame tick starts a walk over all squares, one per clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= UPDATE;
                        idx   <= '0;
                    end
                end
                UPDATE: begin
                    if (idx == IW'(NS - 1)) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Square registers: motion update first, then a CPU write to the same register overrides it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NS; i++) begin
                x0_r[i]   <= '0;
                y0_r[i]   <= '0;
                size_r[i] <= '0;
                col_r[i]  <= RESET_COLOR;
                vx_r[i]   <= '0;
                vy_r[i]   <= '0;
            end
            en_r  <= '0;
            mot_r <= '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (state == UPDATE && idx == IW'(i) && en_r[i] && mot_r[i]) begin
                    {x0_r[i], vx_r[i]} <= bounce(x0_r[i], vx_r[i], size_r[i], H_ACTIVE);
                    {y0_r[i], vy_r[i]} <= bounce(y0_r[i], vy_r[i], size_r[i], V_ACTIVE);
                end
                if (spr_wr && addr[7:3] == 5'(i)) begin
                    case (addr[2:0])
                        3'd0: x0_r[i] <= wr_data[10:0];
                        3'd1: y0_r[i] <= wr_data[10:0];
                        3'd2: begin
                            size_r[i] <= wr_data[SW+1:2];
                            mot_r[i]  <= wr_data[1];
                            en_r[i]   <= wr_data[0];
                        end
                        3'd3: col_r[i] <= wr_data[CD-1:0];
                        3'd4: begin
                            vx_r[i] <= wr_data[3:0];
                            vy_r[i] <= wr_data[7:4];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Global state: bypass, frame tick edge detect, sticky collisions and the frame counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bypass_r    <= 1'b0;
            tick_cond_q <= 1'b0;
            status_r    <= '0;
            live_r      <= '0;
            frame_cnt   <= '0;
        end else begin
            tick_cond_q <= tick_cond;
            if (glb_wr && addr[2:0] == 3'd0) bypass_r <= wr_data[0];
            if (tick) begin
                status_r  <= live_r;
                live_r    <= coll ? hit : '0;
                frame_cnt <= frame_cnt + 16'd1;
            end else if (coll) begin
                live_r <= live_r | hit;
            end
        end
    end

    // Register readback, purely a function of the address.
    always_comb begin
        rd_data = '0;
        if (addr[13]) begin
            if (!addr[12]) begin
                for (int i = 0; i < NS; i++) begin
                    if (addr[7:3] == 5'(i)) begin
                        case (addr[2:0])
                            3'd0:    rd_data = 32'(x0_r[i]);
                            3'd1:    rd_data = 32'(y0_r[i]);
                            3'd2:    rd_data = 32'({size_r[i], mot_r[i], en_r[i]});
                            3'd3:    rd_data = 32'(col_r[i]);
                            3'd4:    rd_data = 32'({vy_r[i], vx_r[i]});
                            default: rd_data = '0;
                        endcase
                    end
                end
            end else begin
                case (addr[2:0])
                    3'd0:    rd_data = 32'(bypass_r);
                    3'd1:    rd_data = 32'(status_r);
                    3'd2:    rd_data = 32'(frame_cnt);
                    default: rd_data = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chu_vga_multi_square_core.sv
// Self-checking bench for the multi-square overlay: directed tables for
// priority and corner cases, plus randomized pixels, collisions and motion
// compared against a behavioural model of the squares.
module tb_chu_vga_multi_square_core;

    localparam int CD = 12;
    localparam int NS = 4;
    localparam int SW = 6;
    localparam int H  = 640;
    localparam int V  = 480;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [10:0]   x = '0;
    logic [10:0]   y = '0;
    logic          cs = 1'b0;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic [13:0]   addr = '0;
    logic [31:0]   wr_data = '0;
    logic [31:0]   rd_data;
    logic [CD-1:0] si_rgb = '0;
    logic [CD-1:0] so_rgb;

    chu_vga_multi_square_core #(
        .CD(CD), .NS(NS), .SW(SW), .KEY_COLOR(12'h000), .H_ACTIVE(H), .V_ACTIVE(V)
    ) dut (
        .clk(clk), .reset_n(reset_n), .x(x), .y(y), .cs(cs), .write(write), .read(read),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .si_rgb(si_rgb), .so_rgb(so_rgb)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural picture of the block
    int m_x0[NS], m_y0[NS], m_size[NS], m_col[NS], m_vx[NS], m_vy[NS];
    bit m_en[NS], m_mot[NS];
    bit m_bypass;
    int m_live, m_status, m_frames;

    typedef struct {
        string name;
        int    px;
        int    py;
        int    si;
        bit    byp;
        int    exp;
    } vec_t;

    vec_t vecs[11];

    function automatic int sreg(int i, int off);
        return 32'h2000 + i * 8 + off;
    endfunction

    function automatic int greg(int off);
        return 32'h3000 + off;
    endfunction

    function automatic int s4(int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    function automatic int neg4(int v);
        return (v == -8) ? 7 : -v;
    endfunction

    function automatic bit model_hit(int i, int px, int py);
        int side = m_size[i] + 1;
        return m_en[i] && m_col[i] != 0 && px >= m_x0[i] && px < m_x0[i] + side
               && py >= m_y0[i] && py < m_y0[i] + side;
    endfunction

    function automatic int model_pix(int px, int py, int si);
        if (m_bypass) return si;
        for (int i = 0; i < NS; i++) if (model_hit(i, px, py)) return m_col[i];
        return si;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_x0[i] = 0; m_y0[i] = 0; m_size[i] = 0; m_col[i] = 'hF00;
            m_vx[i] = 0; m_vy[i] = 0; m_en[i] = 0; m_mot[i] = 0;
        end
        m_bypass = 0; m_live = 0; m_status = 0; m_frames = 0;
    endtask

    task automatic model_axis(inout int p, inout int v, input int side, input int lim);
        int n = p + v;
        if (n < 0) begin
            p = 0; v = neg4(v);
        end else if (n + side > lim) begin
            p = lim - side; v = neg4(v);
        end else begin
            p = n;
        end
    endtask

    task automatic model_tick();
        int p, v;
        m_status = m_live;
        m_live   = 0;
        m_frames = (m_frames + 1) % 65536;
        for (int i = 0; i < NS; i++) begin
            if (m_en[i] && m_mot[i]) begin
                p = m_x0[i]; v = m_vx[i];
                model_axis(p, v, m_size[i] + 1, H);
                m_x0[i] = p; m_vx[i] = v;
                p = m_y0[i]; v = m_vy[i];
                model_axis(p, v, m_size[i] + 1, V);
                m_y0[i] = p; m_vy[i] = v;
            end
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic park();
        x = 11'd700;
        y = 11'd0;
    endtask

    task automatic cpu_write(input int a, input int d);
        int i, off;
        cs = 1'b1; write = 1'b1; addr = 14'(a); wr_data = 32'(d);
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
        off = a & 7;
        if ((a & 'h1000) != 0) begin
            if (off == 0) m_bypass = d[0];
        end else begin
            i = (a >> 3) & 31;
            if (i < NS) begin
                case (off)
                    0: m_x0[i] = d & 'h7FF;
                    1: m_y0[i] = d & 'h7FF;
                    2: begin m_size[i] = (d >> 2) & 63; m_mot[i] = d[1]; m_en[i] = d[0]; end
                    3: m_col[i] = d & 'hFFF;
                    4: begin m_vx[i] = s4(d & 15); m_vy[i] = s4((d >> 4) & 15); end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_reg(input string name, input int a, input int exp);
        cs = 1'b1; read = 1'b1; addr = 14'(a);
        #1;
        check_output(name, rd_data, 32'(exp));
        cs = 1'b0; read = 1'b0;
    endtask

    function automatic int vel_word(int i);
        return ((m_vy[i] & 15) << 4) | (m_vx[i] & 15);
    endfunction

    // Present one pixel for 'hold' clocks, then return the output it produced.
    task automatic apply_stimulus(input int px, input int py, input int si, input int hold,
                                  output logic [31:0] so);
        int cnt, hits;
        x = 11'(px); y = 11'(py); si_rgb = CD'(si);
        repeat (hold) @(posedge clk);
        #1;
        so = 32'(so_rgb);
        cnt = 0; hits = 0;
        for (int i = 0; i < NS; i++) if (model_hit(i, px, py)) begin cnt++; hits |= (1 << i); end
        if (px < H && py < V && cnt >= 2) m_live |= hits;
        park();
    endtask

    task automatic check_pixel(input string name, input int px, input int py, input int si,
                               input int hold);
        logic [31:0] so;
        int exp = model_pix(px, py, si);
        apply_stimulus(px, py, si, hold, so);
        check_output(name, so, 32'(exp));
    endtask

    task automatic frame_tick();
        x = 11'd0; y = 11'(V);
        repeat (4) @(posedge clk);
        #1;
        x = 11'd1;
        @(posedge clk); #1;
        park();
        repeat (NS + 2) @(posedge clk);
        #1;
        model_tick();
    endtask

    initial begin
        logic [31:0] so;
        int side;
        model_reset();
        park();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_output("reset_so", 32'(so_rgb), 32'h0);
        check_reg("reset_col0", sreg(0, 3), 'hF00);

        // Activity, a frame, then reset in the middle of the frame
        cpu_write(sreg(0, 0), 100); cpu_write(sreg(0, 1), 100);
        cpu_write(sreg(0, 2), (9 << 2) | 1); cpu_write(sreg(0, 3), 'h0F0);
        check_pixel("pre_reset_px", 105, 105, 'h123, 1);
        frame_tick();
        check_reg("frame_one", greg(2), 1);
        x = 11'd105; y = 11'd105; si_rgb = 12'h456;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check_output("midreset_so", 32'(so_rgb), 32'h0);
        check_reg("midreset_status", greg(1), 0);
        check_reg("midreset_frame", greg(2), 0);
        check_reg("midreset_col0", sreg(0, 3), 'hF00);
        check_reg("midreset_x0", sreg(0, 0), 0);
        model_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        park();
        check_pixel("post_reset_follow", 105, 105, 'h2A5, 1);

        // Priority table
        cpu_write(sreg(0, 0), 100); cpu_write(sreg(0, 1), 100);
        cpu_write(sreg(0, 2), (9 << 2) | 1); cpu_write(sreg(0, 3), 'h0F0);
        cpu_write(sreg(1, 0), 105); cpu_write(sreg(1, 1), 105);
        cpu_write(sreg(1, 2), (9 << 2) | 1); cpu_write(sreg(1, 3), 'h00F);
        vecs[0]  = '{"pri_overlap",  107, 107, 'h123, 0, 'h0F0};
        vecs[1]  = '{"pri_s1_only",  112, 112, 'h123, 0, 'h00F};
        vecs[2]  = '{"pri_left_out",  99, 100, 'h123, 0, 'h123};
        vecs[3]  = '{"pri_right_out",110, 100, 'h123, 0, 'h123};
        vecs[4]  = '{"pri_s0_corner",109, 109, 'h123, 0, 'h0F0};
        vecs[5]  = '{"pri_s1_after", 110, 110, 'h123, 0, 'h00F};
        vecs[6]  = '{"pri_s1_corner",114, 114, 'h123, 0, 'h00F};
        vecs[7]  = '{"pri_s1_past",  115, 114, 'h123, 0, 'h123};
        vecs[8]  = '{"pri_s0_origin",100, 109, 'h123, 0, 'h0F0};
        vecs[9]  = '{"byp_overlap",  107, 107, 'h123, 1, 'h123};
        vecs[10] = '{"byp_s1",       112, 112, 'h123, 1, 'h123};
        for (int k = 0; k < 11; k++) begin
            if (vecs[k].byp != m_bypass) cpu_write(greg(0), int'(vecs[k].byp));
            apply_stimulus(vecs[k].px, vecs[k].py, vecs[k].si, 1, so);
            check_output(vecs[k].name, so, 32'(vecs[k].exp));
        end
        cpu_write(greg(0), 0);

        // Collision across frames, four clocks per pixel
        frame_tick();
        check_pixel("col_px_a", 107, 107, 'h321, 4);
        check_pixel("col_px_b", 50, 50, 'h321, 4);
        check_pixel("col_px_c", 112, 112, 'h321, 4);
        frame_tick();
        check_reg("col_status_both", greg(1), 3);
        check_reg("col_frame_count", greg(2), m_frames);
        cpu_write(sreg(1, 2), (9 << 2) | 0);
        check_pixel("col_px_d", 107, 107, 'h321, 4);
        frame_tick();
        check_reg("col_status_none", greg(1), 0);
        check_reg("col_frame_next", greg(2), m_frames);

        // Bounce at the right edge and at the left edge with vx=-8
        cpu_write(sreg(0, 0), 630); cpu_write(sreg(0, 4), 3);
        cpu_write(sreg(0, 2), (9 << 2) | 3);
        frame_tick();
        check_reg("bounce_right_x0", sreg(0, 0), 630);
        check_reg("bounce_right_vel", sreg(0, 4), 'h0D);
        frame_tick();
        check_reg("bounce_next_x0", sreg(0, 0), 627);
        cpu_write(sreg(0, 0), 2); cpu_write(sreg(0, 4), 'h08);
        frame_tick();
        check_reg("bounce_left_x0", sreg(0, 0), 0);
        check_reg("bounce_left_vel", sreg(0, 4), 'h07);

        // CPU write to x0 in the very cycle sprite 0 is updated
        cpu_write(sreg(0, 0), 20); cpu_write(sreg(0, 1), 10);
        cpu_write(sreg(0, 4), (1 << 4) | 2);
        x = 11'd0; y = 11'(V);
        @(posedge clk); #1;
        cs = 1'b1; write = 1'b1; addr = 14'(sreg(0, 0)); wr_data = 32'd50;
        @(posedge clk); #1;
        cs = 1'b0; write = 1'b0;
        x = 11'd1;
        @(posedge clk); #1;
        park();
        repeat (NS + 2) @(posedge clk);
        #1;
        model_tick();
        m_x0[0] = 50;
        check_reg("wrcol_x0", sreg(0, 0), 50);
        check_reg("wrcol_y0", sreg(0, 1), 11);
        check_reg("wrcol_vel", sreg(0, 4), 'h12);

        // Key-coloured square is invisible and never collides
        cpu_write(sreg(0, 2), (9 << 2) | 1);
        cpu_write(sreg(0, 0), 100); cpu_write(sreg(0, 1), 100);
        cpu_write(sreg(1, 3), 0); cpu_write(sreg(1, 2), (9 << 2) | 1);
        frame_tick();
        check_pixel("key_hidden", 112, 112, 'h777, 4);
        check_pixel("key_under", 107, 107, 'h777, 4);
        frame_tick();
        check_reg("key_status", greg(1), 0);

        // Randomized pixels and collisions
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NS; i++) begin
                cpu_write(sreg(i, 0), $urandom_range(0, 200));
                cpu_write(sreg(i, 1), $urandom_range(0, 200));
                cpu_write(sreg(i, 3), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 'hFFF));
                cpu_write(sreg(i, 2), ($urandom_range(0, 63) << 2) | int'($urandom_range(0, 3) != 0));
            end
            for (int k = 0; k < 60; k++) begin
                if ($urandom_range(0, 9) == 0) cpu_write(greg(0), int'(!m_bypass));
                check_pixel($sformatf("rnd_px_%0d_%0d", r, k), $urandom_range(0, 270),
                            $urandom_range(0, 270), $urandom_range(0, 'hFFF), $urandom_range(1, 2));
            end
            cpu_write(greg(0), 0);
            frame_tick();
            check_reg($sformatf("rnd_status_%0d", r), greg(1), m_status);
        end

        // Randomized motion over several frames
        for (int i = 0; i < NS; i++) begin
            side = $urandom_range(0, 63);
            cpu_write(sreg(i, 3), $urandom_range(1, 'hFFF));
            cpu_write(sreg(i, 2), (side << 2) | 3);
            cpu_write(sreg(i, 0), $urandom_range(0, H - side - 1));
            cpu_write(sreg(i, 1), $urandom_range(0, V - side - 1));
            cpu_write(sreg(i, 4), $urandom_range(0, 255));
        end
        for (int t = 0; t < 6; t++) begin
            frame_tick();
            for (int i = 0; i < NS; i++) begin
                check_reg($sformatf("mot_x0_%0d_%0d", t, i), sreg(i, 0), m_x0[i]);
                check_reg($sformatf("mot_y0_%0d_%0d", t, i), sreg(i, 1), m_y0[i]);
                check_reg($sformatf("mot_vel_%0d_%0d", t, i), sreg(i, 4), vel_word(i));
            end
        end
        check_reg("final_frame", greg(2), m_frames);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
